// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: coin edge forwarding, motor timing and change payout sequencer
module vend_dispense_ctrl #(
  parameter int unsigned MOTOR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_raw,
  input  logic       two_raw,
  input  logic       five_raw,
  input  logic       d,
  input  logic [2:0] r,
  input  logic       hopper_ack,
  output logic       one,
  output logic       two,
  output logic       five,
  output logic       motor,
  output logic       hopper_req,
  output logic       coin_reject,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, MOTOR, CHG_REQ, CHG_WAIT, DONE} state_t;
  localparam logic [7:0] M_LAST = 8'(MOTOR_CYCLES - 1);
  state_t     r_state;
  logic [2:0] r_cur, r_prev, r_pend;
  logic [7:0] r_cnt;
  logic [2:0] r_left;
  logic       r_armed;
  logic [2:0] w_edge, w_avail, w_pick;
  logic       w_idle, w_cap;
  // bit order in the coin vectors is {five, two, one}, so bit 2 wins priority
  always_comb begin
    w_edge  = r_cur & ~r_prev;
    w_idle  = r_state == IDLE;
    w_avail = r_pend | w_edge;
    w_pick  = w_avail[2] ? 3'b100 : w_avail[1] ? 3'b010 : w_avail[0] ? 3'b001 : 3'b000;
    w_cap   = w_idle && d && r_armed;
  end
  // edge capture, pending set, one-per-cycle forwarding and coin refusal
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur       <= '0;
      r_prev      <= '0;
      r_pend      <= '0;
      {five, two, one} <= '0;
      coin_reject <= 1'b0;
    end else begin
      r_cur       <= {five_raw, two_raw, one_raw};
      r_prev      <= r_cur;
      coin_reject <= w_idle ? |(w_edge & r_pend) : |w_edge;
      {five, two, one} <= w_idle ? w_pick : 3'b000;
      if (w_idle) r_pend <= w_avail & ~w_pick;
    end
  end
  // vend sequencer: motor timing then one hopper handshake per change coin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_left     <= '0;
      r_armed    <= 1'b1;
      motor      <= 1'b0;
      hopper_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (w_cap) r_armed <= 1'b0;
      else if (!d) r_armed <= 1'b1;
      case (r_state)
        IDLE: if (w_cap) begin
          r_state <= MOTOR;
          r_left  <= (r > 3'd4) ? 3'd4 : r;
          r_cnt   <= M_LAST;
          motor   <= 1'b1;
          busy    <= 1'b1;
        end
        MOTOR: if (r_cnt == 8'd0) begin
          motor      <= 1'b0;
          r_state    <= (r_left != 3'd0) ? CHG_REQ : DONE;
          hopper_req <= r_left != 3'd0;
        end else r_cnt <= r_cnt - 8'd1;
        CHG_REQ: if (hopper_ack) begin
          r_left     <= r_left - 3'd1;
          hopper_req <= 1'b0;
          r_state    <= CHG_WAIT;
        end
        CHG_WAIT: if (!hopper_ack) begin
          r_state    <= (r_left != 3'd0) ? CHG_REQ : DONE;
          hopper_req <= r_left != 3'd0;
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          motor      <= 1'b0;
          hopper_req <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: directed and random checks against a behavioural vend model
module tb_vend_dispense_ctrl;
  localparam int M = 8;
  logic clk = 0, reset = 0;
  logic one_raw = 0, two_raw = 0, five_raw = 0, d = 0;
  logic [2:0] r = 0;
  logic hopper_ack = 0;
  logic one, two, five, motor, hopper_req, coin_reject, busy;
  int checks = 0, passed = 0;
  logic run = 0;
  int hlat = 0, hcnt = 0;
  logic hhold = 0, hstick = 0;

  vend_dispense_ctrl #(.MOTOR_CYCLES(M)) dut (
    .clk(clk), .reset(reset), .one_raw(one_raw), .two_raw(two_raw), .five_raw(five_raw),
    .d(d), .r(r), .hopper_ack(hopper_ack), .one(one), .two(two), .five(five),
    .motor(motor), .hopper_req(hopper_req), .coin_reject(coin_reject), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
  endtask

  // hopper: acks after hlat cycles of req, optionally holds ack a random while
  always @(negedge clk) begin
    if (hstick) hopper_ack = 1;
    else if (hopper_req) begin
      if (hcnt >= hlat) hopper_ack = 1;
      else hcnt++;
    end else begin
      hcnt = 0;
      if (!(hhold && $urandom_range(0, 1) == 1)) hopper_ack = 0;
    end
  end

  // model: what's going on in the vend (motor time left, coins owed) rather than FSM states
  logic e_one, e_two, e_five, e_motor, e_req, e_rej, e_busy;
  logic [2:0] pend, h1, h2, edges, avail;
  logic armed, waiting, done, idle;
  int motor_left, owed;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {e_one, e_two, e_five, e_motor, e_req, e_rej, e_busy} = '0;
      pend = 0; h1 = 0; h2 = 0; armed = 1; waiting = 0; done = 0;
      motor_left = 0; owed = 0;
    end else begin
      edges = h1 & ~h2;
      h2 = h1;
      h1 = {five_raw, two_raw, one_raw};
      idle = !e_busy;
      e_rej = idle ? |(edges & pend) : |edges;
      {e_five, e_two, e_one} = 3'b000;
      if (idle) begin
        avail = pend | edges;
        if (avail[2]) e_five = 1;
        else if (avail[1]) e_two = 1;
        else if (avail[0]) e_one = 1;
        pend = avail & ~{e_five, e_two, e_one};
      end
      if (done) done = 0;
      if (waiting && !hopper_ack) begin
        waiting = 0;
        if (owed > 0) e_req = 1; else done = 1;
      end else if (e_req && hopper_ack) begin
        owed--; e_req = 0; waiting = 1;
      end
      if (motor_left > 0) begin
        motor_left--;
        if (motor_left == 0) begin
          if (owed > 0) e_req = 1; else done = 1;
        end
      end
      if (idle && d && armed) begin
        motor_left = M; owed = (r > 4) ? 4 : int'(r); armed = 0;
      end else if (!d) armed = 1;
      e_motor = motor_left > 0;
      e_busy = e_motor || e_req || waiting || done;
    end
  end

  always @(negedge clk)
    if (run) chk("outputs{1,2,5,mot,req,rej,busy}",
                 {one, two, five, motor, hopper_req, coin_reject, busy},
                 {e_one, e_two, e_five, e_motor, e_req, e_rej, e_busy});

  task automatic vend(input logic [2:0] rv, input int dcyc, output int nm, output int nreq,
                      output int nbf, output int first_m);
    logic preq = 0, pbusy = 0;
    nm = 0; nreq = 0; nbf = 0; first_m = -1;
    d = 1; r = rv;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == dcyc - 1) d = 0;
      if (motor) begin nm++; if (first_m < 0) first_m = i; end
      if (hopper_req && !preq) nreq++;
      if (!busy && pbusy) nbf++;
      preq = hopper_req; pbusy = busy;
    end
  endtask

  initial begin
    int nm, nreq, nbf, fm, n1, n2, nrej, bf_i, one_i;
    logic pb;
    logic seen;
    int k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {one, two, five, motor, hopper_req, coin_reject, busy}, 7'd0);
    reset = 1; run = 1;
    repeat (2) @(negedge clk);
    // single coin
    five_raw = 1;
    @(negedge clk); chk("five_t1", five, 0);
    @(negedge clk); chk("five_t2", five, 1); chk("no_reject", coin_reject, 0);
    @(negedge clk); chk("five_t3", five, 0);
    repeat (3) @(negedge clk);
    five_raw = 0;
    repeat (2) @(negedge clk);
    // simultaneous edges
    {five_raw, two_raw, one_raw} = 3'b111;
    @(negedge clk);
    @(negedge clk); chk("simul_t2", {one, two, five}, 3'b001);
    @(negedge clk); chk("simul_t3", {one, two, five}, 3'b010);
    @(negedge clk); chk("simul_t4", {one, two, five}, 3'b100); chk("simul_rej", coin_reject, 0);
    @(negedge clk); chk("simul_t5", {one, two, five}, 3'b000);
    {five_raw, two_raw, one_raw} = 3'b000;
    repeat (3) @(negedge clk);
    // vend with change
    hlat = 1;
    vend(3'd3, 3, nm, nreq, nbf, fm);
    chk("vend3_motor", nm, M); chk("vend3_first_motor", fm, 0);
    chk("vend3_req", nreq, 3); chk("vend3_busyfall", nbf, 1);
    vend(3'd6, 1, nm, nreq, nbf, fm);
    chk("vend6_req", nreq, 4); chk("vend6_motor", nm, M);
    vend(3'd0, 2, nm, nreq, nbf, fm);
    chk("vend0_req", nreq, 0); chk("vend0_motor", nm, M); chk("vend0_busyfall", nbf, 1);
    // coin during vend, pending one held through vend
    {five_raw, one_raw} = 2'b11;
    @(negedge clk);
    d = 1; r = 0;
    n1 = 0; n2 = 0; nrej = 0; bf_i = -1; one_i = -1; pb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) d = 0;
      if (i == 1) two_raw = 1;
      if (one) begin n1++; one_i = i; end
      if (two) n2++;
      if (coin_reject) nrej++;
      if (pb && !busy && bf_i < 0) bf_i = i;
      pb = busy;
    end
    chk("during_vend_one", n1, 1); chk("during_vend_two", n2, 0);
    chk("during_vend_rej", nrej, 1); chk("one_after_busy", one_i, bf_i + 1);
    {five_raw, two_raw, one_raw} = 3'b000;
    repeat (3) @(negedge clk);
    // reset during change wait
    hlat = 0; hstick = 1; d = 1; r = 3;
    @(negedge clk); d = 0;
    seen = 0; k = 0;
    while (k < 40 && !(seen && !hopper_req)) begin
      @(negedge clk);
      if (hopper_req) seen = 1;
      k++;
    end
    chk("reach_chg_wait", {seen, hopper_req}, 2'b10);
    #2 reset = 0;
    #1 chk("reset_async", {one, two, five, motor, hopper_req, coin_reject, busy}, 7'd0);
    repeat (2) @(negedge clk);
    hstick = 0; reset = 1;
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hopper_req || busy) nreq++;
    end
    chk("post_reset_idle", nreq, 0);
    // random traffic
    hhold = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) one_raw = ~one_raw;
      if ($urandom_range(0, 7) == 0) two_raw = ~two_raw;
      if ($urandom_range(0, 7) == 0) five_raw = ~five_raw;
      if ($urandom_range(0, 9) == 0) d = ~d;
      r = 3'($urandom_range(0, 7));
      hlat = $urandom_range(0, 2);
      if (i == 1500) begin #2 reset = 0; #3 reset = 1; end
    end
    d = 0; {five_raw, two_raw, one_raw} = 3'b000;
    repeat (60) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vend_dispense_ctrl.md
# vend_dispense_ctrl

Front-end and back-end sequencer for the AutoBev vending core. Converts raw coin-sensor levels into single-cycle coin pulses (`one`/`two`/`five`) for the core, one pulse per cycle. Captures the core's dispense request `d` and change code `r`, runs the product motor for a fixed time, then pays out change coin-by-coin to the coin hopper over a req/ack handshake. Rejects coins while a vend is in progress.

## Interface
- `MOTOR_CYCLES`, default 8: motor-on duration in clocks; legal range 1-255.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `one_raw`, `two_raw`, `five_raw`  input  1 each: coin sensor levels, already synchronous to `clk`.
- `d`  input  1: dispense request from the vending core.
- `r`  input  3: change count from the vending core, valid with `d`.
- `hopper_ack`  input  1: hopper has ejected one change coin.
- `one`, `two`, `five`  output  1 each: registered single-cycle coin pulses to the core.
- `motor`  output  1: product motor enable.
- `hopper_req`  output  1: request one change coin.
- `coin_reject`  output  1: single-cycle pulse; the coin edge seen last cycle was refused.
- `busy`  output  1: high whenever FSM is not IDLE.

## Operation
- Edge detect: register each `*_raw`. A rising edge is prev=0, cur=1.
- Coin edge while FSM in IDLE:
  - Edge sets pending bit for that coin.
  - Edge on a bit already pending is refused with `coin_reject`.
- Coin edge while `busy`: refused with `coin_reject`; pending bit unchanged.
- Forwarding, IDLE only:
  - Each cycle, the highest-priority pending bit is cleared and its pulse issued next cycle.
  - Priority: five > two > one.
  - At most one of `one`/`two`/`five` is high in any cycle.
  - Pending bits persist through a vend and resume forwarding on return to IDLE.
- d arming:
  - `armed` flag is set when `d`=0 for at least one cycle; reset value 1.
  - In IDLE with `d`=1 and `armed`=1: capture `change_left` = min(`r`,4), clear `armed`, go to MOTOR.
  - `r` values 5-7 saturate to 4.
  - A `d` that stays high for several cycles produces exactly one vend.
- FSM states:
  - IDLE.
  - MOTOR: `motor`=1; counts MOTOR_CYCLES cycles.
    - At count end, go to CHG_REQ if `change_left`>0, else DONE.
  - CHG_REQ: `hopper_req`=1 until `hopper_ack` is sampled high.
    - On ack: decrement `change_left`, drop req, go to CHG_WAIT.
  - CHG_WAIT: `hopper_req`=0; wait until `hopper_ack` is sampled low.
    - Then go to CHG_REQ if `change_left`>0, else DONE.
  - DONE: one cycle, then IDLE.
- Reset (async, any state):
  - FSM goes to IDLE.
  - Pending bits, counter, `change_left` and edge registers clear; `armed`=1.
  - Reset mid-vend abandons the remaining motor time and change.

## Timing
- Reset values: `one`=`two`=`five`=`motor`=`hopper_req`=`coin_reject`=`busy`=0.
- Coin path:
  - Raw rise on cycle t is registered at edge t, edge detected during t+1.
  - Pulse is high during t+2 when no other coin is pending.
  - Simultaneous edges: five at t+2, two at t+3, one at t+4.
- `coin_reject` is high during the cycle after the refusing edge is detected.
- Dispense path:
  - `d` sampled high in IDLE at cycle t.
  - `motor` and `busy` are high from t+1 through t+MOTOR_CYCLES, exactly MOTOR_CYCLES cycles.
- Change path:
  - `hopper_req` rises the cycle after `motor` falls.
  - `hopper_req` falls the cycle after `hopper_ack` is sampled high.
  - Next req rises no earlier than the cycle after `hopper_ack` is sampled low.
  - Minimum 2 cycles per change coin with a combinational-ack hopper.
- `busy` falls one cycle after the last exit from MOTOR or CHG_WAIT (the DONE cycle).
- The first forwarded pending coin is issued the cycle after `busy` falls.
- `d` arriving in the same cycle as a forwarded pulse is captured.
  - Forwarding stops from the next cycle.

## Test plan
- Single coin: `five_raw` 0→1 held 5 cycles → exactly one `five` pulse, 2 cycles after the rise; no reject.
- Simultaneous edges: all three raws rise together → `five`, `two`, `one` on consecutive cycles; no reject.
- Vend with change: `d`=1 held 3 cycles with `r`=3, MOTOR_CYCLES=8, hopper acks 1 cycle after each req → `motor` high 8 cycles, exactly 3 req/ack pairs, `busy` falls once; only one vend.
- Saturation and no change: `r`=6 → 4 hopper coins; `r`=0 → MOTOR then DONE, `hopper_req` never asserts.
- Coin during vend: `two_raw` rises while `motor`=1 → `coin_reject` pulse, no `two` pulse after IDLE. Pending `one` queued before `d` is issued after `busy` falls.
- Reset mid-change: assert `reset`=0 in CHG_WAIT with `change_left`=2 → all outputs 0 immediately; after release, FSM is IDLE and no `hopper_req` occurs.
